// File: rtl/rs_ooo_sched.sv
// Reservation station with multi-port CDB wakeup, issue-time bypass and an
// age-matrix oldest-ready select feeding a registered valid/ready ALU stage.
module rs_ooo_sched #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6,
  parameter int DATA_W    = 32,
  parameter int N_CDB     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          jump_rst,
  input  logic                          issue_valid,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [DATA_W-1:0]             issue_vj,
  input  logic [DATA_W-1:0]             issue_vk,
  input  logic                          issue_pj,
  input  logic                          issue_pk,
  input  logic [ROB_TAG_W-1:0]          issue_qj,
  input  logic [ROB_TAG_W-1:0]          issue_qk,
  input  logic [DATA_W-1:0]             issue_imm,
  input  logic [DATA_W-1:0]             issue_pc,
  input  logic [ROB_TAG_W-1:0]          issue_rob,
  output logic                          rs_full,
  output logic [$clog2(RS_DEPTH):0]     rs_count,
  input  logic [N_CDB-1:0]              cdb_valid,
  input  logic [N_CDB*ROB_TAG_W-1:0]    cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]       cdb_value,
  output logic                          alu_valid,
  input  logic                          alu_ready,
  output logic [OP_W-1:0]               alu_op,
  output logic [DATA_W-1:0]             alu_vj,
  output logic [DATA_W-1:0]             alu_vk,
  output logic [DATA_W-1:0]             alu_imm,
  output logic [DATA_W-1:0]             alu_pc,
  output logic [ROB_TAG_W-1:0]          alu_rob
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]  e_valid, e_pj, e_pk;
  logic [OP_W-1:0]      e_op  [RS_DEPTH];
  logic [DATA_W-1:0]    e_vj  [RS_DEPTH];
  logic [DATA_W-1:0]    e_vk  [RS_DEPTH];
  logic [DATA_W-1:0]    e_imm [RS_DEPTH];
  logic [DATA_W-1:0]    e_pc  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qj  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qk  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_rob [RS_DEPTH];
  // e_older[i][j] set means slot j holds an op accepted before slot i's op
  logic [RS_DEPTH-1:0]  e_older [RS_DEPTH];

  logic [RS_DEPTH-1:0]  wj_hit, wk_hit;
  logic [DATA_W-1:0]    wj_val [RS_DEPTH];
  logic [DATA_W-1:0]    wk_val [RS_DEPTH];
  logic                 bj_hit, bk_hit;
  logic [DATA_W-1:0]    bj_val, bk_val;

  logic [RS_DEPTH-1:0]  ready, pick_oh, disp_mask;
  logic [IDX_W-1:0]     pick_idx, free_idx;
  logic                 free_found, any_ready, load, dispatch, accept;

  assign rs_full = (rs_count == CNT_W'(RS_DEPTH));

  // Tag match against every broadcast port; the first hit in port order wins.
  always_comb begin
    logic [ROB_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    val;
    tag    = '0;
    val    = '0;
    wj_hit = '0;
    wk_hit = '0;
    bj_hit = 1'b0;
    bk_hit = 1'b0;
    bj_val = '0;
    bk_val = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      wj_val[i] = '0;
      wk_val[i] = '0;
    end
    for (int unsigned p = 0; p < N_CDB; p++) begin
      tag = cdb_tag[p*ROB_TAG_W +: ROB_TAG_W];
      val = cdb_value[p*DATA_W +: DATA_W];
      if (cdb_valid[p]) begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
          if (!wj_hit[i] && e_qj[i] == tag) begin
            wj_hit[i] = 1'b1;
            wj_val[i] = val;
          end
          if (!wk_hit[i] && e_qk[i] == tag) begin
            wk_hit[i] = 1'b1;
            wk_val[i] = val;
          end
        end
        if (!bj_hit && issue_qj == tag) begin
          bj_hit = 1'b1;
          bj_val = val;
        end
        if (!bk_hit && issue_qk == tag) begin
          bk_hit = 1'b1;
          bk_val = val;
        end
      end
    end
  end

  assign ready     = e_valid & ~e_pj & ~e_pk;
  assign any_ready = |ready;
  assign load      = !alu_valid || alu_ready;
  assign dispatch  = load && any_ready;
  assign accept    = issue_valid && !rs_full;
  assign disp_mask = dispatch ? pick_oh : '0;

  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      pick_oh[i] = ready[i] && ((e_older[i] & ready) == '0);
      if (pick_oh[i]) pick_idx = IDX_W'(i);
      if (!e_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Control state: validity, pending flags and age relations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid <= '0;
      e_pj    <= '0;
      e_pk    <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) e_older[i] <= '0;
    end else if (jump_rst) begin
      e_valid <= '0;
      e_pj    <= '0;
      e_pk    <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) e_older[i] <= '0;
    end else if (rdy) begin
      e_valid <= e_valid & ~disp_mask;
      e_pj    <= e_pj & ~(e_valid & wj_hit);
      e_pk    <= e_pk & ~(e_valid & wk_hit);
      if (accept) begin
        // A reused slot is younger than everyone: drop its stale column bits.
        for (int unsigned i = 0; i < RS_DEPTH; i++) e_older[i][free_idx] <= 1'b0;
        e_older[free_idx] <= e_valid & ~disp_mask;
        e_valid[free_idx] <= 1'b1;
        e_pj[free_idx]    <= issue_pj && !bj_hit;
        e_pk[free_idx]    <= issue_pk && !bk_hit;
      end
    end
  end

  // Payload needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (rst && !jump_rst && rdy) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (e_pj[i] && wj_hit[i]) e_vj[i] <= wj_val[i];
        if (e_pk[i] && wk_hit[i]) e_vk[i] <= wk_val[i];
      end
      if (accept) begin
        e_op[free_idx]  <= issue_op;
        e_vj[free_idx]  <= (issue_pj && bj_hit) ? bj_val : issue_vj;
        e_vk[free_idx]  <= (issue_pk && bk_hit) ? bk_val : issue_vk;
        e_qj[free_idx]  <= issue_qj;
        e_qk[free_idx]  <= issue_qk;
        e_imm[free_idx] <= issue_imm;
        e_pc[free_idx]  <= issue_pc;
        e_rob[free_idx] <= issue_rob;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_count  <= '0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_rob   <= '0;
    end else if (jump_rst) begin
      rs_count  <= '0;
      alu_valid <= 1'b0;
    end else if (rdy) begin
      if (accept && !dispatch) rs_count <= rs_count + 1'b1;
      else if (!accept && dispatch) rs_count <= rs_count - 1'b1;
      if (load) begin
        alu_valid <= any_ready;
        if (any_ready) begin
          alu_op  <= e_op[pick_idx];
          alu_vj  <= e_vj[pick_idx];
          alu_vk  <= e_vk[pick_idx];
          alu_imm <= e_imm[pick_idx];
          alu_pc  <= e_pc[pick_idx];
          alu_rob <= e_rob[pick_idx];
        end
      end
    end
  end

endmodule
